data_rsp: RTL and testbench

Read-response side of the data block-RAM port. Accepts the address/read-enable stream issued by the data request generator, drives the BRAM read port, tracks in-flight reads across the fixed BRAM latency, and buffers returned words in a small FIFO toward the PE array. Back-pressure is credit-based: `o_stall` goes to the requester's stall input, so no returned word is ever dropped. Sits between the data request generator and the convolution datapath.

---
 rtl/data_rsp.sv | 106 ++++++++++
 tb/tb_data_rsp.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_rsp.sv
// Read-response side of the data BRAM port: issues reads, tracks them across the
// fixed BRAM latency and buffers returned words under credit-based flow control.
`timescale 1ns / 1ps

module data_rsp #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned RAM_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned REG_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_rden,
    output logic                  o_stall,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    output logic                  o_bram_en,
    input  logic [DATA_WIDTH-1:0] i_bram_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_vld,
    input  logic                  i_data_rdy,
    output logic                  o_err_ovf,
    output logic [REG_WIDTH-1:0]  dbg_datarsp_fifo_cnt,
    output logic [REG_WIDTH-1:0]  dbg_datarsp_rd_cnt
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic                   accept;
    logic                   ret;
    logic                   pop;
    logic [RAM_LATENCY-1:0] tag_q, tag_d;
    logic [CntW-1:0]        inflight_q, inflight_d;
    logic [CntW-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic                   err_q;
    logic [REG_WIDTH-1:0]   rd_cnt_q;
    logic [CntW:0]          credit_used;

    // Credits cover both in-flight reads and buffered words, so a push never overflows.
    assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    assign o_stall     = credit_used >= (CntW + 1)'(FIFO_DEPTH);

    assign accept      = i_rden & ~o_stall;
    assign ret         = tag_q[RAM_LATENCY-1];
    assign pop         = o_data_vld & i_data_rdy;

    assign o_bram_en   = accept;
    assign o_bram_addr = i_addr;

    assign o_data_vld  = fifo_cnt_q != '0;
    assign o_data      = mem_q[rd_ptr_q];
    assign o_err_ovf   = err_q;

    assign dbg_datarsp_fifo_cnt = REG_WIDTH'(fifo_cnt_q);
    assign dbg_datarsp_rd_cnt   = rd_cnt_q;

    always_comb begin
        tag_d    = '0;
        tag_d[0] = accept;
        for (int k = 1; k < int'(RAM_LATENCY); k++) begin
            tag_d[k] = tag_q[k-1];
        end
        inflight_d = inflight_q + CntW'(accept) - CntW'(ret);
        fifo_cnt_d = fifo_cnt_q + CntW'(ret) - CntW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q      <= '0;
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
            rd_cnt_q   <= '0;
        end else begin
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (ret) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (i_rden && o_stall) begin
                err_q <= 1'b1;
            end
            if (accept) begin
                rd_cnt_q <= rd_cnt_q + REG_WIDTH'(1);
            end
        end
    end

    // Storage needs no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && ret) begin
            mem_q[wr_ptr_q] <= i_bram_data;
        end
    end

endmodule

// File: tb/tb_data_rsp.sv
// Directed self-checking bench for data_rsp with a two-cycle BRAM model.
`timescale 1ns / 1ps

module tb_data_rsp;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr;
    logic        i_rden;
    logic        o_stall;
    logic [31:0] o_bram_addr;
    logic        o_bram_en;
    logic [31:0] i_bram_data;
    logic [31:0] o_data;
    logic        o_data_vld;
    logic        i_data_rdy;
    logic        o_err_ovf;
    logic [31:0] dbg_datarsp_fifo_cnt;
    logic [31:0] dbg_datarsp_rd_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] bram_a1, bram_a2;

    always #5 clk = ~clk;

    // BRAM: data for the address presented in cycle n is on the bus in cycle n+2.
    always @(posedge clk) begin
        bram_a1 <= o_bram_addr;
        bram_a2 <= bram_a1;
    end
    assign i_bram_data = {16'hA5A5, bram_a2[15:0]};

    data_rsp dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_addr               (i_addr),
        .i_rden               (i_rden),
        .o_stall              (o_stall),
        .o_bram_addr          (o_bram_addr),
        .o_bram_en            (o_bram_en),
        .i_bram_data          (i_bram_data),
        .o_data               (o_data),
        .o_data_vld           (o_data_vld),
        .i_data_rdy           (i_data_rdy),
        .o_err_ovf            (o_err_ovf),
        .dbg_datarsp_fifo_cnt (dbg_datarsp_fifo_cnt),
        .dbg_datarsp_rd_cnt   (dbg_datarsp_rd_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return {16'hA5A5, a[15:0]};
    endfunction

    task automatic pulse_reset();
        rst    = 1'b1;
        i_rden = 1'b0;
        next_cycle();
        rst    = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        i_addr     = '0;
        i_rden     = 1'b0;
        i_data_rdy = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        check("rst_stall", 64'(o_stall), 64'd0);
        check("rst_vld", 64'(o_data_vld), 64'd0);
        check("rst_err", 64'(o_err_ovf), 64'd0);
        check("rst_en", 64'(o_bram_en), 64'd0);
        check("rst_fifo_cnt", 64'(dbg_datarsp_fifo_cnt), 64'd0);
        check("rst_rd_cnt", 64'(dbg_datarsp_rd_cnt), 64'd0);
        next_cycle();

        // Single read
        i_data_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            i_rden = (c == 0);
            i_addr = 32'h10;
            #1;
            if (c == 0) begin
                check("single_en", 64'(o_bram_en), 64'd1);
                check("single_addr", 64'(o_bram_addr), 64'h10);
            end
            check("single_vld", 64'(o_data_vld), 64'(c == 3));
            if (c == 3) check("single_data", 64'(o_data), 64'hA5A5_0010);
            next_cycle();
        end
        check("single_rd_cnt", 64'(dbg_datarsp_rd_cnt), 64'd1);

        // Eight back-to-back reads, consumer always ready
        for (int c = 0; c < 12; c++) begin
            i_rden = (c < 8);
            i_addr = 32'(c);
            #1;
            check("b2b_stall", 64'(o_stall), 64'd0);
            if (c < 8) check("b2b_en", 64'(o_bram_en), 64'd1);
            check("b2b_vld", 64'(o_data_vld), 64'(c >= 3 && c <= 10));
            if (c >= 3 && c <= 10) check("b2b_data", 64'(o_data), 64'(word(32'(c - 3))));
            next_cycle();
        end
        check("b2b_rd_cnt", 64'(dbg_datarsp_rd_cnt), 64'd9);

        // Consumer stalled: four reads fill the credits, then one pop frees one credit
        i_data_rdy = 1'b0;
        for (int c = 0; c < 7; c++) begin
            i_rden = (c < 4);
            i_addr = 32'h20 + 32'(c);
            #1;
            check("fill_stall", 64'(o_stall), 64'(c >= 4));
            check("fill_en", 64'(o_bram_en), 64'(c < 4));
            next_cycle();
        end
        i_rden = 1'b0;
        #1;
        check("fill_fifo_cnt", 64'(dbg_datarsp_fifo_cnt), 64'd4);
        check("fill_head", 64'(o_data), 64'hA5A5_0020);
        i_data_rdy = 1'b1;
        check("pop_stall_same", 64'(o_stall), 64'd1);
        next_cycle();
        i_data_rdy = 1'b0;
        i_rden     = 1'b1;
        i_addr     = 32'h30;
        #1;
        check("credit_stall", 64'(o_stall), 64'd0);
        check("credit_en", 64'(o_bram_en), 64'd1);
        next_cycle();
        i_rden = 1'b0;
        #1;
        check("credit_restall", 64'(o_stall), 64'd1);
        check("credit_rd_cnt", 64'(dbg_datarsp_rd_cnt), 64'd14);
        next_cycle();

        // Push and pop in the same cycle while credits are exhausted
        i_data_rdy = 1'b1;
        #1;
        check("pp_fifo_before", 64'(dbg_datarsp_fifo_cnt), 64'd3);
        check("pp_data0", 64'(o_data), 64'hA5A5_0021);
        next_cycle();
        check("pp_fifo_after", 64'(dbg_datarsp_fifo_cnt), 64'd3);
        check("pp_data1", 64'(o_data), 64'hA5A5_0022);
        next_cycle();
        check("pp_data2", 64'(o_data), 64'hA5A5_0023);
        next_cycle();
        check("pp_data3", 64'(o_data), 64'hA5A5_0030);
        next_cycle();
        check("pp_empty", 64'(o_data_vld), 64'd0);

        // Protocol violation while stalled
        i_data_rdy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            i_rden = 1'b1;
            i_addr = 32'h40 + 32'(c);
            next_cycle();
        end
        i_rden = 1'b1;
        i_addr = 32'h44;
        #1;
        check("ovf_stall", 64'(o_stall), 64'd1);
        check("ovf_en", 64'(o_bram_en), 64'd0);
        check("ovf_err_early", 64'(o_err_ovf), 64'd0);
        next_cycle();
        i_rden = 1'b0;
        check("ovf_err", 64'(o_err_ovf), 64'd1);
        check("ovf_rd_cnt", 64'(dbg_datarsp_rd_cnt), 64'd18);
        i_data_rdy = 1'b1;
        for (int c = 0; c < 6; c++) next_cycle();
        check("ovf_sticky", 64'(o_err_ovf), 64'd1);

        // Reset while two reads are in flight
        pulse_reset();
        #1;
        check("rst2_err", 64'(o_err_ovf), 64'd0);
        for (int c = 0; c < 2; c++) begin
            i_rden = 1'b1;
            i_addr = 32'h50 + 32'(c);
            next_cycle();
        end
        rst    = 1'b1;
        i_rden = 1'b0;
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("midrst_vld", 64'(o_data_vld), 64'd0);
            check("midrst_fifo_cnt", 64'(dbg_datarsp_fifo_cnt), 64'd0);
            check("midrst_stall", 64'(o_stall), 64'd0);
            next_cycle();
        end
        check("midrst_rd_cnt", 64'(dbg_datarsp_rd_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
